// File: rtl/traffic_pkg.sv
// Shared constants for the highway/country-road light controller and its phase timer.
package traffic_pkg;

  localparam logic MODE_LONG  = 1'b0;
  localparam logic MODE_SHORT = 1'b1;

  localparam int DEF_TICK_DIV    = 50_000_000;
  localparam int DEF_LONG_TICKS  = 30;
  localparam int DEF_SHORT_TICKS = 5;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle phase ticks; clr restarts the division, en freezes it.
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;

  assign tick = en && !clr && (pre == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == LAST) ? '0 : pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase-duration timer for the light controller; restarts on every mode_count change.
// Optional TRAFFIC_TIMER_PAUSE_EN adds a pause input that freezes counting.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV    = DEF_TICK_DIV,
  parameter int LONG_TICKS  = DEF_LONG_TICKS,
  parameter int SHORT_TICKS = DEF_SHORT_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_count,
`ifdef TRAFFIC_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             time_out,
  output logic [CNT_W-1:0] remain
);

  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  if (TICK_DIV < 1) begin : g_bad_div
    $error("traffic_phase_timer: TICK_DIV must be at least 1");
  end
  if (LONG_TICKS < 1 || longint'(LONG_TICKS) > CNT_MAX) begin : g_bad_long
    $error("traffic_phase_timer: LONG_TICKS must be 1..2^CNT_W-1");
  end
  if (SHORT_TICKS < 1 || longint'(SHORT_TICKS) > CNT_MAX) begin : g_bad_short
    $error("traffic_phase_timer: SHORT_TICKS must be 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_TICKS);

  logic             mode_q;
  logic [CNT_W-1:0] rem_q;
  logic             done_q;
  logic             restart;
  logic             en;
  logic             tick;

  assign restart = (mode_count != mode_q);

`ifdef TRAFFIC_TIMER_PAUSE_EN
  assign en = !done_q && !pause;
`else
  assign en = !done_q;
`endif

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .en    (en),
    .tick  (tick)
  );

  // Restart wins over a coincident tick; tick already implies counting is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_LONG;
      rem_q  <= LONG_LD;
      done_q <= 1'b0;
    end else if (restart) begin
      mode_q <= mode_count;
      rem_q  <= (mode_count == MODE_SHORT) ? SHORT_LD : LONG_LD;
      done_q <= 1'b0;
    end else if (tick) begin
      rem_q <= rem_q - CNT_W'(1);
      if (rem_q == CNT_W'(1)) begin
        done_q <= 1'b1;
      end
    end
  end

  // Masking with the live mode keeps a stale done from leaking into the next phase.
  assign time_out = done_q && (mode_count == mode_q);
  assign remain   = rem_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Self-checking bench for traffic_phase_timer: directed phase scenarios plus random mode/pause traffic.
module tb_traffic_phase_timer;

  localparam int DIV   = 4;
  localparam int LONG  = 3;
  localparam int SHORT = 2;
  localparam int W     = 4;
`ifdef TRAFFIC_TIMER_PAUSE_EN
  localparam bit HAS_PAUSE = 1'b1;
`else
  localparam bit HAS_PAUSE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         mode_count = 1'b0;
  logic         pause = 1'b0;
  logic         time_out;
  logic [W-1:0] remain;

  int errors = 0;
  int checks = 0;

  // Reference model: phase length in ticks and clk cycles counted toward it.
  int m_mode;
  int m_n;
  int m_active;
  logic [W-1:0] exp_q[$];

  traffic_phase_timer #(
    .TICK_DIV    (DIV),
    .LONG_TICKS  (LONG),
    .SHORT_TICKS (SHORT),
    .CNT_W       (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_count (mode_count),
`ifdef TRAFFIC_TIMER_PAUSE_EN
    .pause      (pause),
`endif
    .time_out   (time_out),
    .remain     (remain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_done();
    return m_active == m_n * DIV;
  endfunction

  function automatic logic [W-1:0] model_remain();
    return W'(m_n - m_active / DIV);
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_n      = LONG;
    m_active = 0;
    exp_q.delete();
    exp_q.push_back(model_remain());
  endtask

  task automatic model_edge(input logic m, input logic p);
    if (int'(m) != m_mode) begin
      m_mode   = int'(m);
      m_n      = m ? SHORT : LONG;
      m_active = 0;
    end else if (!model_done() && !(HAS_PAUSE && p)) begin
      m_active++;
    end
    exp_q.push_back(model_remain());
  endtask

  // One clock: drive at negedge, check registered and masked outputs, then advance the model.
  task automatic step(input logic m, input logic p, output logic seen);
    logic [W-1:0] exp_rem;
    @(negedge clk);
    mode_count = m;
    pause      = p;
    #1;
    exp_rem = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("remain", remain, exp_rem);
    check("time_out", time_out, model_done() && (int'(m) == m_mode));
    seen = time_out;
    @(posedge clk);
    model_edge(m, p);
  endtask

  // Step index of the first time_out (index 0 carries the restart edge, if any).
  task automatic run_until(input logic m, input logic p, input int max, output int lat, output int hi);
    logic seen;
    lat = -1;
    hi  = 0;
    for (int i = 0; i < max; i++) begin
      step(m, p, seen);
      if (seen) begin
        hi++;
        if (lat < 0) lat = i;
      end
    end
  endtask

  // Called while clk is low; reset must act without any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_remain", remain, LONG);
    check("rst_time_out", time_out, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int   lat;
    int   hi;
    int   cnt;
    logic seen;
    logic cur;

    #3;
    do_reset();

    run_until(1'b0, 1'b0, 32, lat, hi);
    check("long_lat", lat, LONG * DIV);
    check("long_hold", hi, 32 - LONG * DIV);

    run_until(1'b1, 1'b0, 16, lat, hi);
    check("short_lat", lat, SHORT * DIV + 1);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, seen);
    run_until(1'b1, 1'b0, 16, lat, hi);
    check("mid_toggle_lat", lat, SHORT * DIV + 1);

    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(logic'(i % 2), 1'b0, seen);
      if (seen) cnt++;
    end
    check("toggle_no_timeout", cnt, 0);

    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, seen);
    @(negedge clk);
    #1;
    check("pre_rst_remain", remain, 1);
    do_reset();
    run_until(1'b0, 1'b0, 16, lat, hi);
    check("post_rst_lat", lat, LONG * DIV);

`ifdef TRAFFIC_TIMER_PAUSE_EN
    step(1'b1, 1'b0, seen);
    step(1'b1, 1'b0, seen);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, seen);
    run_until(1'b1, 1'b0, 16, lat, hi);
    check("pause_lat", lat + 8, SHORT * DIV + 6 + 1);
`endif

    cur = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) cur = ~cur;
      step(cur, logic'($urandom_range(0, 3) == 0), seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
